// File: rtl/wb_pkg.sv
// Shared widths, constants and request type for the writeback arbiter.
package wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO for load results; exposes per-entry valid/address
// so the arbiter can detect pending writes on decode read addresses.
import wb_pkg::*;

module wb_fifo #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [DATA_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            head_addr,
  output logic [DATA_W-1:0]            head_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic                         push_ok;
  logic                         pop_ok;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_addr = entry_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr              <= wr_ptr + PTR_W'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr              <= rd_ptr + PTR_W'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      entry_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr]   <= push_data;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter: ALU has priority, loads are buffered, hazards reported.
// Optional macro WB_LD_BYPASS_EN lets a load skip the empty FIFO for 1-cycle latency.
import wb_pkg::*;

module wb_arbiter #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              haz1,
  output logic              haz2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int ST_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [$clog2(DEPTH):0]       count;
  logic                         full;
  logic                         empty;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
  logic [ST_W-1:0]              starve;
  logic                         alu_take;
  logic                         ld_push;
  logic                         ld_pop;
  logic                         ld_bypass;

  assign alu_ready = (starve < ST_W'(STARVE_MAX));
  assign ld_ready  = !full;
  assign alu_take  = alu_valid && alu_ready;
  assign ld_pop    = !alu_take && !empty;

`ifdef WB_LD_BYPASS_EN
  assign ld_bypass = ld_valid && empty && !alu_take;
`else
  assign ld_bypass = 1'b0;
`endif

  assign ld_push = ld_valid && ld_ready && !ld_bypass;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (ld_push),
    .pop         (ld_pop),
    .push_addr   (ld_addr),
    .push_data   (ld_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Counts ALU-favoured cycles while loads sit in a full FIFO; any dequeue resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (ld_pop) begin
      starve <= '0;
    end else if (full && alu_valid && (starve < ST_W'(STARVE_MAX))) begin
      starve <= starve + ST_W'(1);
    end
  end

  // Writes to x0 are consumed but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (alu_take) begin
      wr_en   <= (alu_addr != ADDR_W'(ZERO_REG));
      wr_addr <= alu_addr;
      wr_data <= alu_data;
    end else if (ld_pop) begin
      wr_en   <= (head_addr != ADDR_W'(ZERO_REG));
      wr_addr <= head_addr;
      wr_data <= head_data;
    end else if (ld_bypass) begin
      wr_en   <= (ld_addr != ADDR_W'(ZERO_REG));
      wr_addr <= ld_addr;
      wr_data <= ld_data;
    end else begin
      wr_en <= 1'b0;
    end
  end

  always_comb begin
    haz1 = wr_en && (wr_addr == rd_addr1);
    haz2 = wr_en && (wr_addr == rd_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == rd_addr1)) haz1 = 1'b1;
      if (entry_valid[i] && (entry_addr[i] == rd_addr2)) haz2 = 1'b1;
    end
    if (rd_addr1 == ADDR_W'(ZERO_REG)) haz1 = 1'b0;
    if (rd_addr2 == ADDR_W'(ZERO_REG)) haz2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter; define WB_LD_BYPASS_EN to match a bypass build.
import wb_pkg::*;

module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        haz1;
  logic        haz2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int    checks = 0;
  int    errors = 0;
  wb_req alu_q[$];
  wb_req ld_q[$];

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .haz1      (haz1),
    .haz2      (haz2),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // One clock step: at the falling edge, retire any visible write against the
  // scoreboard and record accepted requests, then move to just after the rising edge.
  task automatic advance();
    wb_req r;
    @(negedge clk);
    if (!rst && wr_en === 1'b1) begin
      checks++;
      if (alu_q.size() > 0 && alu_q[0].addr == wr_addr && alu_q[0].data == wr_data)
        void'(alu_q.pop_front());
      else if (ld_q.size() > 0 && ld_q[0].addr == wr_addr && ld_q[0].data == wr_data)
        void'(ld_q.pop_front());
      else begin
        errors++;
        $display("[TB] FAIL sb_write: got addr=%0d data=%h, no matching alu/load head (alu pending=%0d ld pending=%0d)",
                 wr_addr, wr_data, alu_q.size(), ld_q.size());
      end
    end
    if (alu_valid && alu_ready && alu_addr != 5'd0) begin
      r.addr = alu_addr; r.data = alu_data; alu_q.push_back(r);
    end
    if (ld_valid && ld_ready && ld_addr != 5'd0) begin
      r.addr = ld_addr; r.data = ld_data; ld_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd4;
    #2;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %0b expected 0", wr_en); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ld_ready: got %0b expected 1", ld_ready); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_alu_ready: got %0b expected 1", alu_ready); end
    checks++; if (haz1 !== 1'b0 || haz2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_haz: got %0b%0b expected 00", haz1, haz2); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF; rd_addr1 = 5'd5;
    #1;
    checks++; if (haz1 !== 1'b0) begin errors++; $display("[TB] FAIL alu_haz_before: got %0b expected 0", haz1); end
    advance();
    idle_inputs();
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL alu_wr_en: got %0b expected 1", wr_en); end
    checks++; if (wr_addr !== 5'd5) begin errors++; $display("[TB] FAIL alu_wr_addr: got %0d expected 5", wr_addr); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL alu_wr_data: got %h expected deadbeef", wr_data); end
    checks++; if (haz1 !== 1'b1) begin errors++; $display("[TB] FAIL alu_haz_during: got %0b expected 1", haz1); end
    advance();
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL alu_wr_en_after: got %0b expected 0", wr_en); end
    checks++; if (haz1 !== 1'b0) begin errors++; $display("[TB] FAIL alu_haz_after: got %0b expected 0", haz1); end
  endtask

  task automatic test_load_only();
    logic exp_c2;
`ifdef WB_LD_BYPASS_EN
    exp_c2 = 1'b1;
`else
    exp_c2 = 1'b0;
`endif
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h1234; rd_addr2 = 5'd7;
    advance();
    idle_inputs();
    #1;
    checks++; if (wr_en !== exp_c2) begin errors++; $display("[TB] FAIL ld_wr_en_c2: got %0b expected %0b", wr_en, exp_c2); end
    checks++; if (haz2 !== 1'b1) begin errors++; $display("[TB] FAIL ld_haz2_c2: got %0b expected 1", haz2); end
    advance();
    #1;
    checks++; if (wr_en !== !exp_c2) begin errors++; $display("[TB] FAIL ld_wr_en_c3: got %0b expected %0b", wr_en, !exp_c2); end
    if (!exp_c2) begin
      checks++; if (wr_addr !== 5'd7 || wr_data !== 32'h1234) begin errors++; $display("[TB] FAIL ld_wr_c3: got %0d/%h expected 7/1234", wr_addr, wr_data); end
    end
    advance();
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL ld_wr_en_c4: got %0b expected 0", wr_en); end
  endtask

  task automatic test_fill_starve();
    logic exp_ld_ready;
    logic exp_alu_ready;
    alu_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      alu_addr = 5'(10 + c); alu_data = 32'hA000_0000 + 32'(c);
      ld_valid = (c <= 4); ld_addr = 5'(c); ld_data = 32'h100 + 32'(c);
      #1;
      exp_ld_ready  = (c <= 4);
      exp_alu_ready = (c <= 7);
      checks++; if (ld_ready !== exp_ld_ready) begin errors++; $display("[TB] FAIL starve_ld_ready c%0d: got %0b expected %0b", c, ld_ready, exp_ld_ready); end
      checks++; if (alu_ready !== exp_alu_ready) begin errors++; $display("[TB] FAIL starve_alu_ready c%0d: got %0b expected %0b", c, alu_ready, exp_alu_ready); end
      advance();
    end
    idle_inputs();
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL starve_alu_ready_back: got %0b expected 1", alu_ready); end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(k) || wr_data !== 32'h100 + 32'(k)) begin
        errors++;
        $display("[TB] FAIL starve_retire %0d: got en=%0b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                 k, wr_en, wr_addr, wr_data, k, 32'h100 + 32'(k));
      end
      advance();
    end
    advance();
  endtask

  task automatic test_x0_drop();
    rd_addr1 = 5'd0;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
    advance();
    alu_valid = 1'b0; ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h66;
    for (int c = 2; c <= 5; c++) begin
      #1;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL x0_wr_en c%0d: got %0b expected 0", c, wr_en); end
      checks++; if (haz1 !== 1'b0) begin errors++; $display("[TB] FAIL x0_haz1 c%0d: got %0b expected 0", c, haz1); end
      advance();
      ld_valid = 1'b0;
    end
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_ld_ready: got %0b expected 1", ld_ready); end
  endtask

  task automatic test_hazard_queued();
    logic exp_haz;
    rd_addr2 = 5'd9;
    alu_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      alu_addr = 5'(11 + c); alu_data = 32'hB000_0000 + 32'(c);
      ld_valid = (c == 1); ld_addr = 5'd9; ld_data = 32'h99;
      #1;
      exp_haz = (c >= 2);
      checks++; if (haz2 !== exp_haz) begin errors++; $display("[TB] FAIL hazq_haz2 c%0d: got %0b expected %0b", c, haz2, exp_haz); end
      advance();
    end
    idle_inputs();
    #1;
    checks++; if (haz2 !== 1'b1) begin errors++; $display("[TB] FAIL hazq_haz2_pop: got %0b expected 1", haz2); end
    advance();
    #1;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd9) begin errors++; $display("[TB] FAIL hazq_write: got en=%0b addr=%0d expected en=1 addr=9", wr_en, wr_addr); end
    checks++; if (haz2 !== 1'b1) begin errors++; $display("[TB] FAIL hazq_haz2_write: got %0b expected 1", haz2); end
    advance();
    #1;
    checks++; if (haz2 !== 1'b0) begin errors++; $display("[TB] FAIL hazq_haz2_after: got %0b expected 0", haz2); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_addr = 5'(16 + c); alu_data = 32'hC000_0000 + 32'(c);
      ld_valid  = 1'b1; ld_addr  = 5'(24 + c); ld_data  = 32'hD000_0000 + 32'(c);
      advance();
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) advance();
    checks++;
    if (alu_q.size() != 0 || ld_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got pending alu=%0d ld=%0d expected 0/0", alu_q.size(), ld_q.size());
    end
  endtask

  task automatic test_async_reset();
    alu_valid = 1'b1; ld_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      alu_addr = 5'(27 + c); alu_data = 32'hE000_0000 + 32'(c);
      ld_addr  = 5'(20 + c); ld_data  = 32'hF000_0000 + 32'(c);
      advance();
    end
    idle_inputs();
    rd_addr2 = 5'd20;
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_wr_en: got %0b expected 1", wr_en); end
    checks++; if (haz2 !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_haz2: got %0b expected 1", haz2); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin errors++; $display("[TB] FAIL arst_outputs: got en=%0b addr=%0d data=%h expected all 0", wr_en, wr_addr, wr_data); end
    checks++; if (haz2 !== 1'b0) begin errors++; $display("[TB] FAIL arst_haz2: got %0b expected 0", haz2); end
    checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_ready: got ld=%0b alu=%0b expected 1/1", ld_ready, alu_ready); end
    alu_q.delete();
    ld_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL arst_stale c%0d: got wr_en=%0b expected 0", c, wr_en); end
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_ld_ready c%0d: got %0b expected 1", c, ld_ready); end
      advance();
    end
  endtask

  initial begin
    $display("[TB] starting wb_arbiter bench");
    test_reset();
    test_alu_only();
    test_load_only();
    test_fill_starve();
    test_x0_drop();
    test_hazard_queued();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (alu_q.size() != 0 || ld_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_drain: got pending alu=%0d ld=%0d expected 0/0", alu_q.size(), ld_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side driver for the processor's 32x32 register file write port (wr_en/wr_addr/wr_data).
- Merges two result producers onto the single write port:
  - the ALU path, which has priority;
  - the load path, which is buffered in a small FIFO.
- Reports pending-write hazards on the two register read addresses so decode can stall.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- DEPTH, 4, load FIFO entries (power of 2, >=2).
- STARVE_MAX, 3, consecutive full-FIFO cycles tolerated before the ALU is back-pressured.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle (alu_valid && alu_ready).
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load result present.
- ld_ready  out  1  load FIFO can accept.
- ld_addr  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load data.
- rd_addr1  in  ADDR_W  decode read address 1 (hazard check).
- rd_addr2  in  ADDR_W  decode read address 2 (hazard check).
- haz1  out  1  rd_addr1 has a pending write.
- haz2  out  1  rd_addr2 has a pending write.
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  ADDR_W  register file write address (registered).
- wr_data  out  DATA_W  register file write data (registered).

Behaviour:
- Reset (async, rst=1):
  - wr_en=0, wr_addr=0, wr_data=0.
  - FIFO empty (count=0, pointers=0), starve counter=0.
  - ld_ready=1, alu_ready=1. haz1/haz2 follow reset state (0).
  - Reset mid-operation discards all queued loads; no write is issued after rst rises.
- FIFO:
  - ld_ready = (count != DEPTH); enqueue when ld_valid && ld_ready.
  - Pointers wrap modulo DEPTH.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Enqueue is never attempted when full.
- Starve counter:
  - Increments each cycle the FIFO is full and alu_valid=1, saturating at STARVE_MAX.
  - Clears on any dequeue.
  - alu_ready = (starve < STARVE_MAX).
- Output select, evaluated every cycle:
  1. If alu_valid && alu_ready: register the ALU result.
  2. Else if FIFO non-empty: dequeue the head and register it.
  3. Else: wr_en <= 0 (wr_addr/wr_data hold).
- Latency:
  - ALU accepted in cycle N -> wr_en high in cycle N+1.
  - Load enqueued in N -> earliest wr_en in N+2 (see Optional Feature).
- x0 rule: results with addr 0 are consumed normally (accepted/dequeued) but produce wr_en=0.
- Hazards (combinational):
  - haz1 = (rd_addr1 != 0) && (rd_addr1 matches any valid FIFO entry, or wr_en && wr_addr == rd_addr1).
  - haz2 is identical for rd_addr2.
- Ordering: loads retire in enqueue order. No ordering is guaranteed between the ALU and load paths; the producer avoids same-destination races using haz1/haz2.

Optional Feature:
- Macro WB_LD_BYPASS_EN.
- Defined: when the FIFO is empty, the ALU is not accepted this cycle, and ld_valid=1, the load goes straight to the output registers without being enqueued. Load latency becomes N -> N+1.
- Undefined: every load passes through the FIFO; minimum latency is 2.

Decomposition:
- Shared package wb_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the ZERO_REG constant;
  - a wb_req struct typedef {addr, data}.
- One natural sub-module: wb_fifo (DEPTH-entry synchronous FIFO). It exposes count/full/empty and per-entry valid plus address for the hazard compare.
- Arbitration, starve counter and hazard logic stay in wb_arbiter.

Test Plan:
- ALU only: alu_valid=1, addr=5, data=0xDEADBEEF in cycle 1 -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in cycle 2; haz on rd_addr1=5 during cycle 2.
- Load only, bypass off: ld_valid=1, addr=7, data=0x1234 in cycle 1 -> wr_en in cycle 3.
  - With WB_LD_BYPASS_EN: wr_en in cycle 2.
- Fill and starve:
  - Hold alu_valid=1 continuously; push 4 loads (addrs 1-4) -> ld_ready=0 after the 4th.
  - After 3 full cycles alu_ready=0; loads 1-4 then retire in order; alu_ready returns to 1 after the first dequeue.
- x0 drop: alu addr=0, then ld addr=0 -> both accepted, wr_en stays 0, haz1 stays 0 with rd_addr1=0.
- Hazard on queued load: enqueue ld addr=9 while the ALU is busy; rd_addr2=9 -> haz2=1 until the cycle after the write retires, then 0.
- Async reset: assert rst with 3 loads queued and wr_en=1 -> outputs go to 0 immediately without a clock edge; after release, ld_ready=1 and no stale writes appear.
